// File: rtl/sd_read_ctrl.sv
// SD file reader supervisor: reset sequencing, hang detection with retry,
// and a first-word fall-through byte FIFO toward the consumer.
module sd_read_ctrl #(
    parameter int          RST_CYCLES     = 1000,
    parameter int          TIMEOUT_CYCLES = 1 << 24,
    parameter int          MAX_RETRY      = 3,
    parameter logic [3:0]  DONE_STAT      = 4'd15,
    parameter int          FIFO_DEPTH     = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic        reader_rstn,
    input  logic [3:0]  card_stat,
    input  logic        file_found,
    input  logic        outen,
    input  logic [7:0]  outbyte,
    output logic        m_valid,
    output logic [7:0]  m_data,
    input  logic        m_ready,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic [1:0]  retry_cnt,
    output logic        overflow,
    output logic [23:0] byte_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_DONE,
        S_FAIL
    } state_t;

    state_t        state, state_n;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] timer;
    logic [3:0]    prev_stat;

    logic          start_ok;
    logic          timeout;
    logic          retry_inc;
    logic          set_err;
    logic [1:0]    err_n;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wptr, rptr;
    logic          empty, full;
    logic          run, push, pop, drop;

    assign run         = (state == S_RUN);
    assign reader_rstn = run;
    assign busy        = (state == S_HOLD) || run;
    assign done        = (state == S_DONE);

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign m_valid = !empty;
    assign m_data  = mem[rptr[AW-1:0]];
    assign pop     = m_valid && m_ready;
    assign push    = run && outen && (!full || pop);
    assign drop    = run && outen && full && !pop;

    assign start_ok = start &&
                      (state == S_IDLE || state == S_DONE || state == S_FAIL);
    assign timeout  = run && (timer == TW'(TIMEOUT_CYCLES));

    always_comb begin
        state_n   = state;
        retry_inc = 1'b0;
        set_err   = 1'b0;
        err_n     = err_code;
        unique case (state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) state_n = S_HOLD;
            end
            S_HOLD: begin
                if (hold_cnt == HW'(RST_CYCLES - 1)) state_n = S_RUN;
            end
            S_RUN: begin
                // End-of-file status wins over a coincident timeout
                if (card_stat == DONE_STAT) begin
                    if (file_found) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_FAIL;
                        set_err = 1'b1;
                        err_n   = 2'd2;
                    end
                end else if (timeout) begin
                    if (byte_cnt != '0) begin
                        state_n = S_FAIL;
                        set_err = 1'b1;
                        err_n   = 2'd3;
                    end else if (retry_cnt < 2'(MAX_RETRY)) begin
                        state_n   = S_HOLD;
                        retry_inc = 1'b1;
                    end else begin
                        state_n = S_FAIL;
                        set_err = 1'b1;
                        err_n   = 2'd1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            hold_cnt  <= '0;
            timer     <= '0;
            prev_stat <= '0;
        end else begin
            state     <= state_n;
            prev_stat <= card_stat;
            hold_cnt  <= (state == S_HOLD) ? hold_cnt + HW'(1) : '0;
            if (!run || card_stat != prev_stat || outen)
                timer <= '0;
            else
                timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            retry_cnt <= '0;
            err_code  <= '0;
            overflow  <= 1'b0;
            byte_cnt  <= '0;
            wptr      <= '0;
            rptr      <= '0;
        end else if (start_ok) begin
            retry_cnt <= '0;
            err_code  <= '0;
            overflow  <= 1'b0;
            byte_cnt  <= '0;
            wptr      <= '0;
            rptr      <= '0;
        end else begin
            if (retry_inc) retry_cnt <= retry_cnt + 2'd1;
            if (set_err)   err_code  <= err_n;
            if (drop)      overflow  <= 1'b1;
            if (push && byte_cnt != '1) byte_cnt <= byte_cnt + 24'd1;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= outbyte;
    end

endmodule

// File: tb/tb_sd_read_ctrl.sv
// Directed bench for sd_read_ctrl: streaming, retries, not-found,
// overflow, mid-stream hang and asynchronous reset abort.
module tb_sd_read_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        reader_rstn;
    logic [3:0]  card_stat;
    logic        file_found;
    logic        outen;
    logic [7:0]  outbyte;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;
    logic [1:0]  retry_cnt;
    logic        overflow;
    logic [23:0] byte_cnt;

    int total  = 0;
    int passed = 0;

    sd_read_ctrl #(
        .RST_CYCLES    (4),
        .TIMEOUT_CYCLES(50),
        .MAX_RETRY     (3),
        .DONE_STAT     (4'd15),
        .FIFO_DEPTH    (16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .reader_rstn(reader_rstn),
        .card_stat  (card_stat),
        .file_found (file_found),
        .outen      (outen),
        .outbyte    (outbyte),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .busy       (busy),
        .done       (done),
        .err_code   (err_code),
        .retry_cnt  (retry_cnt),
        .overflow   (overflow),
        .byte_cnt   (byte_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start pulse, then wait out the 4-cycle reader reset into RUN
    task automatic go();
        card_stat  = 4'd0;
        file_found = 1'b0;
        outen      = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; card_stat = 4'd0; file_found = 1'b0;
        outen = 1'b0; outbyte = 8'd0; m_ready = 1'b0;
        repeat (2) tick();
        total++;
        if ({reader_rstn, m_valid, busy, done, overflow} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000",
                     {reader_rstn, m_valid, busy, done, overflow});
        else passed++;
        total++;
        if ({err_code, retry_cnt, byte_cnt} !== 28'd0)
            $display("FAIL reset_counts: err=%0d retry=%0d bytes=%0d want 0",
                     err_code, retry_cnt, byte_cnt);
        else passed++;
        rstn = 1'b1;
        repeat (3) tick();
        total++;
        if (busy !== 1'b0 || reader_rstn !== 1'b0)
            $display("FAIL reset_idle: busy=%b rrstn=%b want 0 0",
                     busy, reader_rstn);
        else passed++;
    endtask

    task automatic test_stream();
        card_stat = 4'd0; m_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || reader_rstn !== 1'b0)
            $display("FAIL hold_entry: busy=%b rrstn=%b want 1 0",
                     busy, reader_rstn);
        else passed++;
        repeat (3) tick();
        total++;
        if (reader_rstn !== 1'b0)
            $display("FAIL rrstn_cycle4: got %b want 0", reader_rstn);
        else passed++;
        tick();
        total++;
        if (reader_rstn !== 1'b1)
            $display("FAIL rrstn_cycle5: got %b want 1", reader_rstn);
        else passed++;
        card_stat = 4'd1;
        for (int i = 0; i < 20; i++) begin
            outen = 1'b1; outbyte = 8'(i);
            tick();
            total++;
            if (m_valid !== 1'b1 || m_data !== 8'(i))
                $display("FAIL stream_byte%0d: valid=%b data=%0d want 1 %0d",
                         i, m_valid, m_data, i);
            else passed++;
        end
        outen = 1'b0;
        tick();
        total++;
        if (m_valid !== 1'b0)
            $display("FAIL stream_drained: valid=%b want 0", m_valid);
        else passed++;
        card_stat = 4'd15; file_found = 1'b1;
        tick();
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || reader_rstn !== 1'b0)
            $display("FAIL stream_done: done=%b busy=%b rrstn=%b want 1 0 0",
                     done, busy, reader_rstn);
        else passed++;
        total++;
        if (byte_cnt !== 24'd20 || err_code !== 2'd0)
            $display("FAIL stream_count: bytes=%0d err=%0d want 20 0",
                     byte_cnt, err_code);
        else passed++;
    endtask

    task automatic test_retry();
        m_ready = 1'b0;
        go();
        total++;
        if (reader_rstn !== 1'b1 || err_code !== 2'd0 || done !== 1'b0)
            $display("FAIL retry_run: rrstn=%b err=%0d done=%b want 1 0 0",
                     reader_rstn, err_code, done);
        else passed++;
        for (int r = 1; r <= 3; r++) begin
            for (int k = 0; k < 200 && reader_rstn; k++) tick();
            total++;
            if (reader_rstn !== 1'b0 || busy !== 1'b1 ||
                retry_cnt !== 2'(r))
                $display("FAIL retry_hold%0d: rrstn=%b busy=%b retry=%0d want 0 1 %0d",
                         r, reader_rstn, busy, retry_cnt, r);
            else passed++;
            for (int k = 0; k < 20 && !reader_rstn; k++) tick();
        end
        for (int k = 0; k < 200 && reader_rstn; k++) tick();
        total++;
        if (busy !== 1'b0 || err_code !== 2'd1 || reader_rstn !== 1'b0 ||
            retry_cnt !== 2'd3 || done !== 1'b0)
            $display("FAIL retry_exhaust: busy=%b err=%0d rrstn=%b retry=%0d done=%b want 0 1 0 3 0",
                     busy, err_code, reader_rstn, retry_cnt, done);
        else passed++;
    endtask

    task automatic test_not_found();
        go();
        card_stat = 4'd3;
        tick();
        card_stat = 4'd15; file_found = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || err_code !== 2'd2 ||
            byte_cnt !== 24'd0 || retry_cnt !== 2'd0)
            $display("FAIL not_found: busy=%b done=%b err=%0d bytes=%0d retry=%0d want 0 0 2 0 0",
                     busy, done, err_code, byte_cnt, retry_cnt);
        else passed++;
    endtask

    task automatic test_overflow();
        m_ready = 1'b0;
        go();
        for (int i = 0; i < 18; i++) begin
            outen = 1'b1; outbyte = 8'(i);
            tick();
            if (i == 15) begin
                total++;
                if (overflow !== 1'b0 || byte_cnt !== 24'd16)
                    $display("FAIL ovf_at_full: ovf=%b bytes=%0d want 0 16",
                             overflow, byte_cnt);
                else passed++;
            end
        end
        outen = 1'b0;
        tick();
        total++;
        if (overflow !== 1'b1 || byte_cnt !== 24'd16 || m_valid !== 1'b1)
            $display("FAIL ovf_after: ovf=%b bytes=%0d valid=%b want 1 16 1",
                     overflow, byte_cnt, m_valid);
        else passed++;
        total++;
        if (m_data !== 8'd0)
            $display("FAIL ovf_stall: data=%0d want 0", m_data);
        else passed++;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (m_valid !== 1'b1 || m_data !== 8'(i))
                $display("FAIL ovf_drain%0d: valid=%b data=%0d want 1 %0d",
                         i, m_valid, m_data, i);
            else passed++;
            tick();
        end
        total++;
        if (m_valid !== 1'b0 || overflow !== 1'b1)
            $display("FAIL ovf_empty: valid=%b ovf=%b want 0 1",
                     m_valid, overflow);
        else passed++;
        card_stat = 4'd15; file_found = 1'b1;
        tick();
        go();
        total++;
        if (overflow !== 1'b0 || byte_cnt !== 24'd0)
            $display("FAIL ovf_clear: ovf=%b bytes=%0d want 0 0",
                     overflow, byte_cnt);
        else passed++;
    endtask

    task automatic test_hang();
        m_ready = 1'b0;
        go();
        for (int i = 0; i < 5; i++) begin
            outen = 1'b1; outbyte = 8'hA0 + 8'(i);
            tick();
        end
        outen = 1'b0;
        for (int k = 0; k < 200 && busy; k++) tick();
        total++;
        if (busy !== 1'b0 || err_code !== 2'd3 || retry_cnt !== 2'd0 ||
            byte_cnt !== 24'd5)
            $display("FAIL hang_fail: busy=%b err=%0d retry=%0d bytes=%0d want 0 3 0 5",
                     busy, err_code, retry_cnt, byte_cnt);
        else passed++;
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (m_valid !== 1'b1 || m_data !== 8'hA0 + 8'(i))
                $display("FAIL hang_drain%0d: valid=%b data=%h want 1 %h",
                         i, m_valid, m_data, 8'hA0 + 8'(i));
            else passed++;
            tick();
        end
        total++;
        if (m_valid !== 1'b0)
            $display("FAIL hang_empty: valid=%b want 0", m_valid);
        else passed++;
    endtask

    task automatic test_async_abort();
        m_ready = 1'b0;
        go();
        card_stat = 4'd2;
        for (int i = 0; i < 3; i++) begin
            outen = 1'b1; outbyte = 8'h50 + 8'(i);
            tick();
        end
        outen = 1'b0;
        total++;
        if (m_valid !== 1'b1 || reader_rstn !== 1'b1 || byte_cnt !== 24'd3)
            $display("FAIL abort_pre: valid=%b rrstn=%b bytes=%0d want 1 1 3",
                     m_valid, reader_rstn, byte_cnt);
        else passed++;
        rstn = 1'b0;
        #1;
        total++;
        if (m_valid !== 1'b0 || reader_rstn !== 1'b0 || busy !== 1'b0 ||
            byte_cnt !== 24'd0)
            $display("FAIL abort_now: valid=%b rrstn=%b busy=%b bytes=%0d want 0 0 0 0",
                     m_valid, reader_rstn, busy, byte_cnt);
        else passed++;
        #1;
        rstn = 1'b1;
        repeat (3) tick();
        total++;
        if (busy !== 1'b0 || reader_rstn !== 1'b0 || done !== 1'b0 ||
            m_valid !== 1'b0)
            $display("FAIL abort_idle: busy=%b rrstn=%b done=%b valid=%b want 0 0 0 0",
                     busy, reader_rstn, done, m_valid);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_retry();
        test_not_found();
        test_overflow();
        test_hang();
        test_async_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sd_read_ctrl.md
SD_READ_CTRL -- requirements
Module: sd_read_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 1000, cycles the reader is held in reset per attempt.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2^24, no-progress cycles before an attempt is declared hung.
REQ-003 SHALL have parameter MAX_RETRY, default 3, re-attempts allowed after the first attempt.
REQ-004 SHALL have parameter DONE_STAT, default 4'd15, the card_stat value meaning the reader has finished the file.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, a power of two and at least 2, output byte buffer depth.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, a one-cycle pulse that begins a read from IDLE, DONE or FAIL.
REQ-009 SHALL have port reader_rstn, output, 1, active-low reset driven to the SD file reader.
REQ-010 SHALL have ports card_stat (input, 4), file_found (input, 1), outen (input, 1) and outbyte (input, 8), all status and data from the reader.
REQ-011 SHALL have ports m_valid (output, 1), m_data (output, 8) and m_ready (input, 1), the byte stream to the consumer.
REQ-012 SHALL have port busy, output, 1, high in HOLD or RUN.
REQ-013 SHALL have port done, output, 1, high in DONE.
REQ-014 SHALL have port err_code, output, 2, where 0 means none, 1 means retries exhausted, 2 means file not found, and 3 means hang mid-stream.
REQ-015 SHALL have ports retry_cnt (output, 2), overflow (output, 1, sticky dropped-byte flag) and byte_cnt (output, 24, bytes accepted into the FIFO).

Function
REQ-016 SHALL implement the states IDLE, HOLD, RUN, DONE and FAIL.
REQ-017 SHALL drive reader_rstn low in IDLE, HOLD, DONE and FAIL, and high only in RUN.
REQ-018 SHALL, on start in IDLE, DONE or FAIL, clear retry_cnt, err_code, overflow, byte_cnt and the FIFO, and enter HOLD; start is ignored in HOLD and RUN.
REQ-019 SHALL stay in HOLD for exactly RST_CYCLES cycles, then enter RUN, so reader_rstn rises RST_CYCLES+1 cycles after the start cycle.
REQ-020 SHALL keep a progress timer in RUN that clears on entry, clears on any card_stat change from the previous cycle, clears on outen, and otherwise increments.
REQ-021 SHALL, when the timer reaches TIMEOUT_CYCLES and byte_cnt is 0 and retry_cnt is below MAX_RETRY, increment retry_cnt and return to HOLD.
REQ-022 SHALL, when the timer reaches TIMEOUT_CYCLES and byte_cnt is 0 and retry_cnt equals MAX_RETRY, enter FAIL with err_code 1.
REQ-023 SHALL, when the timer reaches TIMEOUT_CYCLES and byte_cnt is nonzero, enter FAIL with err_code 3 and not retry.
REQ-024 SHALL, in RUN when card_stat equals DONE_STAT, enter DONE if file_found is 1, else enter FAIL with err_code 2.
REQ-025 SHALL give DONE_STAT priority over timeout when both occur in the same cycle.
REQ-026 SHALL, in RUN when outen is 1, push outbyte if the FIFO is not full or a pop occurs in the same cycle, and increment byte_cnt.
REQ-027 SHALL, when outen is 1 with the FIFO full and no pop, drop the byte, leave byte_cnt unchanged and set overflow to 1.
REQ-028 SHALL keep overflow set until the next accepted start or reset.
REQ-029 SHALL saturate byte_cnt at 2^24-1.
REQ-030 SHALL ignore outen outside RUN.
REQ-031 SHALL drive m_valid as FIFO non-empty, with m_data the head byte (registered FIFO, first-word fall-through).
REQ-032 SHALL pop on m_valid && m_ready.
REQ-033 SHALL hold m_data stable while m_valid is 1 and m_ready is 0.
REQ-034 SHALL give each pushed byte a latency of 1 cycle to m_valid when the FIFO is empty.
REQ-035 SHALL keep the FIFO drainable in DONE and FAIL, and flush it only on start.
REQ-036 SHALL implement the FIFO pointers with log2(FIFO_DEPTH)+1 bits, wrapping modulo 2*FIFO_DEPTH.

Reset
REQ-037 SHALL, while rstn is low, asynchronously force state IDLE, reader_rstn 0, m_valid 0, busy 0, done 0, err_code 0, retry_cnt 0, overflow 0, byte_cnt 0, and the FIFO empty.
REQ-038 SHALL, on rstn low mid-RUN, abort immediately, drop reader_rstn and discard FIFO contents.
REQ-039 SHALL, after rstn rises, wait in IDLE for start.

Verification
REQ-040 SHALL verify that start with RST_CYCLES=4 gives reader_rstn rising on cycle 5, then a model streaming 20 bytes with m_ready=1 and card_stat stepping to 15 with file_found=1 yields done=1, byte_cnt=20 and err_code 0.
REQ-041 SHALL verify that with TIMEOUT_CYCLES=50, MAX_RETRY=3 and a frozen card_stat with no bytes, retry_cnt steps 1..3 with a HOLD before each, then FAIL with err_code 1 and reader_rstn 0.
REQ-042 SHALL verify that card_stat reaching 15 with file_found=0 gives FAIL with err_code 2 and byte_cnt 0.
REQ-043 SHALL verify that FIFO_DEPTH=16, m_ready=0 and 18 outen pulses give 16 bytes held, overflow=1 and byte_cnt=16, then draining with m_ready=1 returns bytes 0..15 in order.
REQ-044 SHALL verify that a timeout after 5 bytes pushed gives FAIL with err_code 3 and retry_cnt 0, and that the 5 bytes remain drainable.
REQ-045 SHALL verify that rstn pulsed low mid-stream with 3 bytes buffered gives m_valid 0 and reader_rstn 0 in the same cycle, and IDLE after release.
